// File: rtl/hora_pkg.sv
// Shared definitions for the hora_editor time-edit stage: FSM encoding,
// cursor field indices, BCD limits and wrap-around BCD step helpers.
package hora_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   localparam logic [1:0] F_HOUR = 2'd0;
   localparam logic [1:0] F_MIN  = 2'd1;
   localparam logic [1:0] F_SEC  = 2'd2;

   localparam logic [7:0] HOUR_MAX   = 8'h23;
   localparam logic [7:0] MINSEC_MAX = 8'h59;

   // Values at or above max wrap to zero, so a corrupted field self-heals.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if (v >= max) begin
         r = 8'h00;
      end else if (v[3:0] >= 4'h9) begin
         r = {v[7:4] + 4'h1, 4'h0};
      end else begin
         r = {v[7:4], v[3:0] + 4'h1};
      end
      return r;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if ((v == 8'h00) || (v > max)) begin
         r = max;
      end else if (v[3:0] == 4'h0) begin
         r = {v[7:4] - 4'h1, 4'h9};
      end else begin
         r = {v[7:4], v[3:0] - 4'h1};
      end
      return r;
   endfunction

endpackage

// File: rtl/hora_editor_btn_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stable-level debounce
// counter and a one-cycle pulse on the rising edge of the filtered level.
module btn_debounce #(
   parameter logic [15:0] CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   logic        sync1_q, sync2_q;
   logic        level_q, level_d;
   logic        press_q, press_d;
   logic [15:0] cnt_q, cnt_d;

   // Count consecutive samples that disagree with the accepted level.
   always_comb begin
      level_d = level_q;
      cnt_d   = 16'd0;
      if (sync2_q != level_q) begin
         if (cnt_q >= (CYCLES - 16'd1)) begin
            level_d = sync2_q;
            cnt_d   = 16'd0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end else begin
         cnt_d = 16'd0;
      end
      press_d = level_d & ~level_q;
   end

   // Synchronizer, filter and pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= 16'd0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/hora_editor.sv
// Time register and user-edit stage: tracks the RTC in IDLE, applies debounced
// BCD edits in EDIT, hands the result to the RTC writer in COMMIT.
// Optional feature macro: EDIT_TIMEOUT_EN (abort an idle edit session).
module hora_editor
   import hora_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
`ifdef EDIT_TIMEOUT_EN
   ,
   parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rtc_load,
   input  logic [7:0] rtc_hour,
   input  logic [7:0] rtc_min,
   input  logic [7:0] rtc_sec,
   input  logic       btn_prog,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       write_ack,
   output logic [7:0] hour_in1,
   output logic [7:0] hour_in2,
   output logic [7:0] hour_in3,
   output logic       programar_on,
   output logic [3:0] direccion_actual_pantalla,
   output logic       okmaquina,
   output logic       write_req,
   output logic [7:0] wr_hour,
   output logic [7:0] wr_min,
   output logic [7:0] wr_sec
);

   logic p_prog, p_left, p_right, p_up, p_down;
   logic timeout_s;

   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prog  (.clk(clk), .reset(reset), .btn_raw(btn_prog),  .press(p_prog));
   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_left  (.clk(clk), .reset(reset), .btn_raw(btn_left),  .press(p_left));
   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_right (.clk(clk), .reset(reset), .btn_raw(btn_right), .press(p_right));
   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(clk), .reset(reset), .btn_raw(btn_up),    .press(p_up));
   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk(clk), .reset(reset), .btn_raw(btn_down),  .press(p_down));

   state_e     state_q, state_d;
   logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
   logic [7:0] wr_hour_q, wr_hour_d, wr_min_q, wr_min_d, wr_sec_q, wr_sec_d;
   logic [1:0] cursor_q, cursor_d;
   logic       ok_q, ok_d, prog_q, prog_d, req_q, req_d;

`ifdef EDIT_TIMEOUT_EN
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        any_press_s;

   // Inactivity counter, only running while the user is editing.
   always_comb begin
      any_press_s = p_prog | p_left | p_right | p_up | p_down;
      if ((state_q == ST_EDIT) && !any_press_s) begin
         to_cnt_d = to_cnt_q + 32'd1;
      end else begin
         to_cnt_d = 32'd0;
      end
      timeout_s = (state_q == ST_EDIT) && (to_cnt_q >= (TIMEOUT_CYCLES - 32'd1));
   end

   // Inactivity counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q <= 32'd0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = p_prog ? ST_EDIT : ST_IDLE;
         ST_EDIT: begin
            if (p_prog) begin
               state_d = ST_COMMIT;
            end else if (timeout_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_EDIT;
            end
         end
         ST_COMMIT: state_d = write_ack ? ST_IDLE : ST_COMMIT;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      logic [7:0] sel_s, max_s, new_s;
      hour_d    = hour_q;
      min_d     = min_q;
      sec_d     = sec_q;
      wr_hour_d = wr_hour_q;
      wr_min_d  = wr_min_q;
      wr_sec_d  = wr_sec_q;
      cursor_d  = cursor_q;
      ok_d      = ok_q;
      sel_s     = 8'h00;
      max_s     = MINSEC_MAX;
      new_s     = 8'h00;
      case (cursor_q)
         F_HOUR:  begin sel_s = hour_q; max_s = HOUR_MAX;   end
         F_MIN:   begin sel_s = min_q;  max_s = MINSEC_MAX; end
         F_SEC:   begin sel_s = sec_q;  max_s = MINSEC_MAX; end
         default: begin sel_s = 8'h00;  max_s = MINSEC_MAX; end
      endcase
      if (p_up && !p_down) begin
         new_s = bcd_inc(sel_s, max_s);
      end else if (p_down && !p_up) begin
         new_s = bcd_dec(sel_s, max_s);
      end else begin
         new_s = sel_s;
      end
      case (state_q)
         ST_IDLE: begin
            if (rtc_load) begin
               hour_d = rtc_hour;
               min_d  = rtc_min;
               sec_d  = rtc_sec;
               ok_d   = 1'b1;
            end else begin
               ok_d = ok_q;
            end
            if (p_prog) begin
               cursor_d = F_HOUR;
            end else begin
               cursor_d = cursor_q;
            end
         end
         ST_EDIT: begin
            // A commit press wins over simultaneous edits so wr_* match the display.
            if (p_prog) begin
               wr_hour_d = hour_q;
               wr_min_d  = min_q;
               wr_sec_d  = sec_q;
            end else begin
               case (cursor_q)
                  F_HOUR:  hour_d = new_s;
                  F_MIN:   min_d  = new_s;
                  F_SEC:   sec_d  = new_s;
                  default: hour_d = hour_q;
               endcase
               if (p_right && !p_left) begin
                  cursor_d = (cursor_q >= F_SEC) ? F_HOUR : cursor_q + 2'd1;
               end else if (p_left && !p_right) begin
                  cursor_d = (cursor_q == F_HOUR) ? F_SEC : cursor_q - 2'd1;
               end else begin
                  cursor_d = cursor_q;
               end
            end
         end
         ST_COMMIT: cursor_d = cursor_q;
         default:   cursor_d = F_HOUR;
      endcase
      prog_d = (state_d != ST_IDLE);
      req_d  = (state_d == ST_COMMIT);
   end

   // Time fields, write data and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hour_q    <= 8'h00;
         min_q     <= 8'h00;
         sec_q     <= 8'h00;
         wr_hour_q <= 8'h00;
         wr_min_q  <= 8'h00;
         wr_sec_q  <= 8'h00;
         cursor_q  <= F_HOUR;
         ok_q      <= 1'b0;
         prog_q    <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         hour_q    <= hour_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         wr_hour_q <= wr_hour_d;
         wr_min_q  <= wr_min_d;
         wr_sec_q  <= wr_sec_d;
         cursor_q  <= cursor_d;
         ok_q      <= ok_d;
         prog_q    <= prog_d;
         req_q     <= req_d;
      end
   end

   assign hour_in1                  = hour_q;
   assign hour_in2                  = min_q;
   assign hour_in3                  = sec_q;
   assign programar_on              = prog_q;
   assign direccion_actual_pantalla = {2'b00, cursor_q};
   assign okmaquina                 = ok_q;
   assign write_req                 = req_q;
   assign wr_hour                   = wr_hour_q;
   assign wr_min                    = wr_min_q;
   assign wr_sec                    = wr_sec_q;

endmodule

// File: tb/tb_hora_editor.sv
// Self-checking bench for hora_editor: directed boundary cases plus random
// edit sequences compared against a decimal-arithmetic model of the time.
module tb_hora_editor;

   logic       clk = 1'b0;
   logic       reset;
   logic       rtc_load;
   logic [7:0] rtc_hour, rtc_min, rtc_sec;
   logic       btn_prog, btn_left, btn_right, btn_up, btn_down;
   logic       write_ack;
   logic [7:0] hour_in1, hour_in2, hour_in3;
   logic       programar_on;
   logic [3:0] direccion_actual_pantalla;
   logic       okmaquina, write_req;
   logic [7:0] wr_hour, wr_min, wr_sec;

   hora_editor #(.DEBOUNCE_CYCLES(16'd4)) dut (
      .clk(clk), .reset(reset), .rtc_load(rtc_load),
      .rtc_hour(rtc_hour), .rtc_min(rtc_min), .rtc_sec(rtc_sec),
      .btn_prog(btn_prog), .btn_left(btn_left), .btn_right(btn_right),
      .btn_up(btn_up), .btn_down(btn_down), .write_ack(write_ack),
      .hour_in1(hour_in1), .hour_in2(hour_in2), .hour_in3(hour_in3),
      .programar_on(programar_on),
      .direccion_actual_pantalla(direccion_actual_pantalla),
      .okmaquina(okmaquina), .write_req(write_req),
      .wr_hour(wr_hour), .wr_min(wr_min), .wr_sec(wr_sec)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] M_PROG = 5'b00001;
   localparam logic [4:0] M_LEFT = 5'b00010;
   localparam logic [4:0] M_RGHT = 5'b00100;
   localparam logic [4:0] M_UP   = 5'b01000;
   localparam logic [4:0] M_DOWN = 5'b10000;

   int n_tests = 0;
   int n_fail  = 0;
   int m_h = 0, m_m = 0, m_s = 0, m_cur = 0;
   bit m_prog = 1'b0;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_view(input string tag);
      check_eq({tag, "_hour"}, 32'(hour_in1), 32'(to_bcd(m_h)));
      check_eq({tag, "_min"},  32'(hour_in2), 32'(to_bcd(m_m)));
      check_eq({tag, "_sec"},  32'(hour_in3), 32'(to_bcd(m_s)));
      check_eq({tag, "_cur"},  32'(direccion_actual_pantalla), 32'(m_cur));
      check_eq({tag, "_prog"}, 32'(programar_on), 32'(m_prog));
   endtask

   // Behavioural view of one accepted edit press: decimal modulo arithmetic.
   task automatic model_edit(input logic [4:0] mask);
      bit up, dn, lf, rt;
      up = mask[3]; dn = mask[4]; lf = mask[1]; rt = mask[2];
      if (up != dn) begin
         case (m_cur)
            0: m_h = up ? (m_h + 1) % 24 : (m_h + 23) % 24;
            1: m_m = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
            default: m_s = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
         endcase
      end
      if (rt && !lf) m_cur = (m_cur + 1) % 3;
      if (lf && !rt) m_cur = (m_cur + 2) % 3;
   endtask

   task automatic press(input logic [4:0] mask, input int hold);
      @(negedge clk);
      {btn_down, btn_up, btn_right, btn_left, btn_prog} = mask;
      repeat (hold) @(negedge clk);
      {btn_down, btn_up, btn_right, btn_left, btn_prog} = 5'b00000;
      repeat (12) @(negedge clk);
   endtask

   task automatic load(input int h, input int m, input int s);
      @(negedge clk);
      rtc_hour = to_bcd(h); rtc_min = to_bcd(m); rtc_sec = to_bcd(s);
      rtc_load = 1'b1;
      @(negedge clk);
      rtc_load = 1'b0;
   endtask

   initial begin
      logic [4:0] mask;
      reset = 1'b1; rtc_load = 1'b0; write_ack = 1'b0;
      rtc_hour = 8'h00; rtc_min = 8'h00; rtc_sec = 8'h00;
      {btn_down, btn_up, btn_right, btn_left, btn_prog} = 5'b00000;
      repeat (3) @(negedge clk);
      check_view("reset");
      check_eq("reset_ok",  32'(okmaquina), 32'd0);
      check_eq("reset_req", 32'(write_req), 32'd0);
      reset = 1'b0;

      load(12, 34, 56);
      m_h = 12; m_m = 34; m_s = 56;
      check_view("load1");
      check_eq("load1_ok", 32'(okmaquina), 32'd1);

      load(23, 10, 59);
      m_h = 23; m_m = 10; m_s = 59;
      check_view("load2");

      press(M_PROG, 10); m_prog = 1'b1; m_cur = 0;
      check_view("enter_edit");
      press(M_UP, 10);   model_edit(M_UP);   check_view("hour_23_up");
      press(M_DOWN, 10); model_edit(M_DOWN); check_view("hour_00_dn");
      press(M_RGHT, 10); model_edit(M_RGHT); check_view("right1");
      press(M_DOWN, 10); model_edit(M_DOWN); check_view("min_10_dn");
      press(M_RGHT, 10); model_edit(M_RGHT); check_view("right2");
      press(M_UP, 10);   model_edit(M_UP);   check_view("sec_59_up");
      press(M_RGHT, 10); model_edit(M_RGHT); check_view("right_wrap");
      press(M_LEFT, 10); model_edit(M_LEFT); check_view("left_wrap");
      press(M_RGHT, 10); model_edit(M_RGHT); check_view("back_to_hour");

      press(M_UP, 3);                        check_view("bounce3");
      press(M_UP, 5);    model_edit(M_UP);   check_view("held5");
      press(M_UP | M_DOWN, 10);              check_view("up_and_down");
      press(M_RGHT | M_UP, 10); model_edit(M_RGHT | M_UP); check_view("cur_and_val");

      for (int i = 0; i < 40; i++) begin
         mask = 5'($urandom_range(1, 15)) << 1;
         press(mask, 10);
         model_edit(mask);
         check_view($sformatf("rand%0d", i));
      end

      load(1, 1, 1);
      check_view("load_in_edit");

      press(M_PROG, 10);
      check_eq("commit_req",  32'(write_req), 32'd1);
      check_eq("commit_wr_h", 32'(wr_hour), 32'(to_bcd(m_h)));
      check_eq("commit_wr_m", 32'(wr_min),  32'(to_bcd(m_m)));
      check_eq("commit_wr_s", 32'(wr_sec),  32'(to_bcd(m_s)));
      check_view("commit");
      repeat (10) @(negedge clk);
      check_eq("ack_wait_req", 32'(write_req), 32'd1);
      press(M_UP | M_RGHT, 10);
      check_view("commit_btn_ignored");
      check_eq("commit_btn_req", 32'(write_req), 32'd1);

      @(negedge clk); write_ack = 1'b1;
      @(negedge clk); write_ack = 1'b0;
      m_prog = 1'b0;
      check_eq("ack_req", 32'(write_req), 32'd0);
      check_view("after_ack");
      @(negedge clk); write_ack = 1'b1;
      @(negedge clk); write_ack = 1'b0;
      check_eq("idle_ack_req", 32'(write_req), 32'd0);

      m_h = $urandom_range(0, 23); m_m = $urandom_range(0, 59); m_s = $urandom_range(0, 59);
      load(m_h, m_m, m_s);
      check_view("load_idle_again");

      press(M_PROG, 10); m_prog = 1'b1; m_cur = 0;
      for (int i = 0; i < 8; i++) begin
         mask = 5'($urandom_range(1, 15)) << 1;
         press(mask, 10);
         model_edit(mask);
      end
      check_view("edit2");
      press(M_PROG, 10);
      check_eq("commit2_req",  32'(write_req), 32'd1);
      check_eq("commit2_wr_h", 32'(wr_hour), 32'(to_bcd(m_h)));

      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      m_h = 0; m_m = 0; m_s = 0; m_cur = 0; m_prog = 1'b0;
      check_eq("async_rst_req",  32'(write_req), 32'd0);
      check_eq("async_rst_ok",   32'(okmaquina), 32'd0);
      check_eq("async_rst_wr_h", 32'(wr_hour),   32'd0);
      check_view("async_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
